// File: rtl/iot_riscv_csr_pkg.sv
// Shared definitions for the iot_riscv machine-mode CSR file and trap controller:
// CSR addresses, the CSR operation encoding, mstatus/mie/mip bit positions,
// mcause codes and the mtvec mode encoding.
package iot_riscv_csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // mstatus / mie / mip bit positions
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LO   = 11;
  localparam int unsigned MSTATUS_MPP_HI   = 12;
  localparam int unsigned MIE_MTIE_BIT     = 7;
  localparam int unsigned MIE_MEIE_BIT     = 11;
  localparam int unsigned MIP_MTIP_BIT     = 7;
  localparam int unsigned MIP_MEIP_BIT     = 11;

  // mcause codes
  localparam logic [3:0] MCAUSE_IRQ_TIMER   = 4'd7;
  localparam logic [3:0] MCAUSE_IRQ_EXT     = 4'd11;
  localparam logic [3:0] MCAUSE_EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] MCAUSE_EXC_BREAK   = 4'd3;
  localparam logic [3:0] MCAUSE_EXC_ECALL   = 4'd11;

  typedef enum logic {
    TVEC_DIRECT   = 1'b0,
    TVEC_VECTORED = 1'b1
  } tvec_mode_e;

endpackage

// File: rtl/iot_riscv_csr_cnt.sv
// One machine counter (mcycle or minstret).
// Ports: main_clk_i/main_rst_an_i (sync, active-low reset), inc_en_i (count
// enable), wr_lo_i/wr_hi_i with wdata_i (replace low/high 32-bit half),
// cnt_o (count zero-extended to 64 bits).
// A write to either half takes precedence over the increment in that cycle.
module iot_riscv_csr_cnt #(
  parameter int unsigned cnt_width_p = 64
) (
  input  logic        main_clk_i,
  input  logic        main_rst_an_i,
  input  logic        inc_en_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [cnt_width_p-1:0] cnt_q;
  logic [cnt_width_p-1:0] cnt_d;
  logic [63:0]            wr_val;

  always_comb begin
    cnt_o = '0;
    cnt_o[cnt_width_p-1:0] = cnt_q;
    wr_val = cnt_o;
    if (wr_lo_i) wr_val[31:0]  = wdata_i;
    if (wr_hi_i) wr_val[63:32] = wdata_i;
    if (wr_lo_i || wr_hi_i) cnt_d = wr_val[cnt_width_p-1:0];
    else if (inc_en_i)      cnt_d = cnt_q + cnt_width_p'(1);
    else                    cnt_d = cnt_q;
  end

  always_ff @(posedge main_clk_i) begin
    if (!main_rst_an_i) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

endmodule

// File: rtl/iot_riscv_csr_trap.sv
// Machine-mode CSR file and trap controller for the iot_riscv core.
// Ports:
//   main_clk_i, main_rst_an_i         clock, synchronous active-low reset
//   csr_op_i/addr_i/wdata_i/wsup_i    CSRRW/RS/RC request from EX
//   csr_rdata_o, csr_illegal_o        old CSR value / illegal flag (combinational)
//   trap_i, trap_irq_i, trap_cause_i,
//   trap_pc_i, trap_tval_i            trap entry request and its context
//   mret_i                            return from trap
//   instr_ret_i                       retire pulse for minstret
//   irq_ext_i, irq_timer_i            level interrupt lines
//   irq_pending_o, trap_vec_o, mepc_o to fetch
// Build option: IOT_RISCV_CSR_COUNTERS_EN implements mcycle/minstret(h);
// without it those addresses stay legal, read 0 and ignore writes.
module iot_riscv_csr_trap
  import iot_riscv_csr_pkg::*;
#(
  parameter int unsigned pc_size_p   = 32,
  parameter int unsigned cnt_width_p = 64,
  parameter logic [31:0] mtvec_rst_p = 32'h0000_0000
) (
  input  logic                 main_clk_i,
  input  logic                 main_rst_an_i,
  input  logic [1:0]           csr_op_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [31:0]          csr_wdata_i,
  input  logic                 csr_wsup_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_illegal_o,
  input  logic                 trap_i,
  input  logic                 trap_irq_i,
  input  logic [3:0]           trap_cause_i,
  input  logic [pc_size_p-1:0] trap_pc_i,
  input  logic [31:0]          trap_tval_i,
  input  logic                 mret_i,
  input  logic                 instr_ret_i,
  input  logic                 irq_ext_i,
  input  logic                 irq_timer_i,
  output logic                 irq_pending_o,
  output logic [pc_size_p-1:0] trap_vec_o,
  output logic [pc_size_p-1:0] mepc_o
);

  csr_op_e op;
  assign op = csr_op_e'(csr_op_i);

  logic                 mst_mie_q, mst_mpie_q;
  logic                 mie_mtie_q, mie_meie_q;
  logic [31:0]          mtvec_q;
  logic [31:0]          mscratch_q;
  logic [pc_size_p-1:0] mepc_q;
  logic                 mcause_irq_q;
  logic [3:0]           mcause_code_q;
  logic [31:0]          mtval_q;
  logic [63:0]          cyc_val, ret_val;

  logic [31:0] mstatus_rd, mie_rd, mip_rd, mcause_rd, mepc_rd;
  logic [31:0] rd_val, wval;
  logic        csr_impl, csr_wr_req, csr_we;

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE_BIT]  = mst_mie_q;
    mstatus_rd[MSTATUS_MPIE_BIT] = mst_mpie_q;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mie_rd = '0;
    mie_rd[MIE_MTIE_BIT] = mie_mtie_q;
    mie_rd[MIE_MEIE_BIT] = mie_meie_q;
    mip_rd = '0;
    mip_rd[MIP_MTIP_BIT] = irq_timer_i;
    mip_rd[MIP_MEIP_BIT] = irq_ext_i;
    mcause_rd = {mcause_irq_q, 27'b0, mcause_code_q};
    mepc_rd = '0;
    mepc_rd[pc_size_p-1:0] = mepc_q;
  end

  // Read mux; also decides whether the address is implemented.
  always_comb begin
    csr_impl = 1'b1;
    rd_val   = '0;
    case (csr_addr_i)
      CSR_MSTATUS:   rd_val = mstatus_rd;
      CSR_MISA:      rd_val = MISA_VALUE;
      CSR_MIE:       rd_val = mie_rd;
      CSR_MTVEC:     rd_val = mtvec_q;
      CSR_MSCRATCH:  rd_val = mscratch_q;
      CSR_MEPC:      rd_val = mepc_rd;
      CSR_MCAUSE:    rd_val = mcause_rd;
      CSR_MTVAL:     rd_val = mtval_q;
      CSR_MIP:       rd_val = mip_rd;
      CSR_MCYCLE:    rd_val = cyc_val[31:0];
      CSR_MCYCLEH:   rd_val = cyc_val[63:32];
      CSR_MINSTRET:  rd_val = ret_val[31:0];
      CSR_MINSTRETH: rd_val = ret_val[63:32];
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: rd_val = '0;
      default:       csr_impl = 1'b0;
    endcase
  end

  assign csr_wr_req    = (op != CSR_OP_NONE) &&
                         !(csr_wsup_i && (op == CSR_OP_RS || op == CSR_OP_RC));
  assign csr_illegal_o = (op != CSR_OP_NONE) &&
                         (!csr_impl || (csr_wr_req && csr_addr_i[11:10] == 2'b11));
  assign csr_rdata_o   = csr_illegal_o ? '0 : rd_val;
  // Trap and mret both drop a concurrent CSR write completely.
  assign csr_we        = csr_wr_req && !csr_illegal_o && !trap_i && !mret_i;

  always_comb begin
    case (op)
      CSR_OP_RW: wval = csr_wdata_i;
      CSR_OP_RS: wval = rd_val | csr_wdata_i;
      CSR_OP_RC: wval = rd_val & ~csr_wdata_i;
      default:   wval = rd_val;
    endcase
  end

  always_ff @(posedge main_clk_i) begin
    if (!main_rst_an_i) begin
      mst_mie_q     <= 1'b0;
      mst_mpie_q    <= 1'b0;
      mie_mtie_q    <= 1'b0;
      mie_meie_q    <= 1'b0;
      mtvec_q       <= {mtvec_rst_p[31:2], 1'b0, mtvec_rst_p[0]};
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_irq_q  <= 1'b0;
      mcause_code_q <= '0;
      mtval_q       <= '0;
    end else if (trap_i) begin
      mepc_q        <= {trap_pc_i[pc_size_p-1:1], 1'b0};
      mcause_irq_q  <= trap_irq_i;
      mcause_code_q <= trap_cause_i;
      mtval_q       <= trap_tval_i;
      mst_mpie_q    <= mst_mie_q;
      mst_mie_q     <= 1'b0;
    end else if (mret_i) begin
      mst_mie_q     <= mst_mpie_q;
      mst_mpie_q    <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mst_mie_q  <= wval[MSTATUS_MIE_BIT];
          mst_mpie_q <= wval[MSTATUS_MPIE_BIT];
        end
        CSR_MIE: begin
          mie_mtie_q <= wval[MIE_MTIE_BIT];
          mie_meie_q <= wval[MIE_MEIE_BIT];
        end
        CSR_MTVEC:    mtvec_q    <= {wval[31:2], 1'b0, wval[0]};
        CSR_MSCRATCH: mscratch_q <= wval;
        CSR_MEPC:     mepc_q     <= {wval[pc_size_p-1:1], 1'b0};
        CSR_MCAUSE: begin
          mcause_irq_q  <= wval[31];
          mcause_code_q <= wval[3:0];
        end
        CSR_MTVAL:    mtval_q    <= wval;
        default: ;
      endcase
    end
  end

  assign irq_pending_o = mst_mie_q &
                         ((irq_timer_i & mie_mtie_q) | (irq_ext_i & mie_meie_q));
  assign mepc_o = mepc_q;

  logic [pc_size_p-1:0] tvec_base;
  assign tvec_base = {mtvec_q[pc_size_p-1:2], 2'b00};

  always_comb begin
    trap_vec_o = tvec_base;
    if (tvec_mode_e'(mtvec_q[0]) == TVEC_VECTORED && trap_irq_i)
      trap_vec_o = tvec_base + {{(pc_size_p-6){1'b0}}, trap_cause_i, 2'b00};
  end

  logic unused_trap_pc0;
  assign unused_trap_pc0 = trap_pc_i[0];

`ifdef IOT_RISCV_CSR_COUNTERS_EN
  iot_riscv_csr_cnt #(.cnt_width_p(cnt_width_p)) u_mcycle (
    .main_clk_i    (main_clk_i),
    .main_rst_an_i (main_rst_an_i),
    .inc_en_i      (1'b1),
    .wr_lo_i       (csr_we && csr_addr_i == CSR_MCYCLE),
    .wr_hi_i       (csr_we && csr_addr_i == CSR_MCYCLEH),
    .wdata_i       (wval),
    .cnt_o         (cyc_val)
  );

  iot_riscv_csr_cnt #(.cnt_width_p(cnt_width_p)) u_minstret (
    .main_clk_i    (main_clk_i),
    .main_rst_an_i (main_rst_an_i),
    .inc_en_i      (instr_ret_i),
    .wr_lo_i       (csr_we && csr_addr_i == CSR_MINSTRET),
    .wr_hi_i       (csr_we && csr_addr_i == CSR_MINSTRETH),
    .wdata_i       (wval),
    .cnt_o         (ret_val)
  );
`else
  assign cyc_val = '0;
  assign ret_val = '0;
  logic unused_instr_ret;
  assign unused_instr_ret = instr_ret_i;
`endif

endmodule
